// File: rtl/fetch_queue_way0.sv
// ---------------------------------------------------------------------------
// fetch_queue_way0
//
// Purpose:
//   In-order instruction queue between the way-0 PC unit / instruction SRAM
//   and the way-0 decoder. Each fetched {instAddr, inst} pair is written into
//   a DEPTH-entry circular buffer. The head entry is offered to the decoder
//   through a valid/ready handshake. A taken jump (flush_i) empties the queue.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset          in   asynchronous, active-high reset
//   valid_i        in   fetch side presents {instAddr_i, inst_i} this cycle
//   instAddr_i     in   [DATA_W] address of the fetched instruction
//   inst_i         in   [DATA_W] instruction word from SRAM
//   flush_i        in   taken jump: drop queued and incoming entries
//   decodeReady_i  in   decoder accepts the head entry this cycle
//   ready_o        out  back-pressure to PC unit, high = at least 2 free slots
//   valid_o        out  head entry valid (occupancy != 0)
//   instAddr_o     out  [DATA_W] head entry address
//   inst_o         out  [DATA_W] head entry instruction
//   count_o        out  [$clog2(DEPTH)+1] occupancy, 0..DEPTH
//   overflow_o     out  sticky: a valid_i was dropped because the queue was full
// ---------------------------------------------------------------------------
module fetch_queue_way0 #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic [DATA_W-1:0]          instAddr_i,
    input  logic [DATA_W-1:0]          inst_i,
    input  logic                       flush_i,
    input  logic                       decodeReady_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          instAddr_o,
    output logic [DATA_W-1:0]          inst_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy thresholds, sized to the counter to keep comparisons exact.
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] READY_MAX  = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] EMPTY_CNT  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              overflow_d;

    // Handshake qualifiers for the current cycle.
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    // Qualify push/pop/drop; flush overrides everything this cycle.
    always_comb begin
        full_s  = (count_q == FULL_CNT);
        empty_s = (count_q == EMPTY_CNT);
        if (flush_i) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
            drop_s = 1'b0;
        end else begin
            pop_s  = !empty_s && decodeReady_i;
            // A pop on a full queue frees the slot the push writes into.
            push_s = valid_i && (!full_s || pop_s);
            drop_s = valid_i && full_s && !pop_s;
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            // Stored entries are left in place; count = 0 makes them unreachable.
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = EMPTY_CNT;
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Control registers: pointers, occupancy, overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= EMPTY_CNT;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage: cleared on reset, written at wr_ptr on an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= {DATA_W{1'b0}};
                inst_mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                addr_mem_q[wr_ptr_q] <= instAddr_i;
                inst_mem_q[wr_ptr_q] <= inst_i;
            end
        end
    end

    // Head and status outputs, decoded from registered state only (no bypass).
    always_comb begin
        valid_o    = !empty_s;
        instAddr_o = addr_mem_q[rd_ptr_q];
        inst_o     = inst_mem_q[rd_ptr_q];
        count_o    = count_q;
        // Two-slot margin: the PC unit can issue one more valid after ready_o drops.
        ready_o    = (count_q <= READY_MAX);
        overflow_o = overflow_q;
    end

endmodule
